// File: rtl/osd_spi_master_if.sv
// Command and row-data handshake between on-chip logic and the OSD SPI master.
interface osd_spi_master_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic       cmd_enable;
    logic [2:0] cmd_row;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;

    modport master (
        output cmd_valid, cmd_write, cmd_enable, cmd_row, data_in, data_valid,
        input  cmd_ready, data_ready
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_enable, cmd_row, data_in, data_valid,
        output cmd_ready, data_ready
    );
endinterface

// File: rtl/osd_spi_master.sv
// SPI transmitter driving the OSD command link: enable/disable frames and
// row-write frames (command byte followed by ROW_BYTES data bytes).
module osd_spi_master #(
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned ROW_BYTES = 256
) (
    input  logic             clk_sys,
    input  logic             reset,
    osd_spi_master_if.slave  bus,
    output logic             busy,
    output logic             done,
    output logic             SPI_SCK,
    output logic             SPI_SS3,
    output logic             SPI_DI
);
    localparam int unsigned DIV_W  = 8;
    localparam int unsigned BIT_W  = 3;
    localparam int unsigned BYTE_W = 9;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [BYTE_W-1:0] ROW_COUNT = BYTE_W'(ROW_BYTES);

    typedef enum logic [2:0] {
        IDLE,
        LOW,
        HIGH,
        LOAD,
        FINISH,
        GAP
    } state_e;

    state_e            state_q;
    logic [DIV_W-1:0]  div_q;
    logic [BIT_W-1:0]  bitcnt_q;
    logic [BYTE_W-1:0] bytecnt_q;
    logic [7:0]        shift_q;
    logic              row_q;
    logic              rdy_q;
    logic              dreq_q;
    logic              busy_q;
    logic              done_q;
    logic              sck_q;
    logic              ss_q;
    logic              di_q;

    logic [7:0]        cmd_byte_c;
    logic              div_end_c;

    assign cmd_byte_c = bus.cmd_write ? (8'h20 | {5'd0, bus.cmd_row})
                                      : (8'h40 | {7'd0, bus.cmd_enable});
    assign div_end_c  = (div_q == DIV_LAST);

    assign bus.cmd_ready  = rdy_q;
    assign bus.data_ready = dreq_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign SPI_SCK        = sck_q;
    assign SPI_SS3        = ss_q;
    assign SPI_DI         = di_q;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q   <= IDLE;
            div_q     <= '0;
            bitcnt_q  <= '0;
            bytecnt_q <= '0;
            shift_q   <= '0;
            row_q     <= 1'b0;
            rdy_q     <= 1'b1;
            dreq_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sck_q     <= 1'b0;
            ss_q      <= 1'b1;
            di_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.cmd_valid && rdy_q) begin
                        rdy_q     <= 1'b0;
                        busy_q    <= 1'b1;
                        ss_q      <= 1'b0;
                        row_q     <= bus.cmd_write;
                        shift_q   <= cmd_byte_c;
                        di_q      <= cmd_byte_c[7];
                        bitcnt_q  <= '0;
                        bytecnt_q <= '0;
                        div_q     <= '0;
                        state_q   <= LOW;
                    end
                end
                LOW: begin
                    if (div_end_c) begin
                        div_q   <= '0;
                        sck_q   <= 1'b1;
                        state_q <= HIGH;
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end
                HIGH: begin
                    if (div_end_c) begin
                        div_q <= '0;
                        sck_q <= 1'b0;
                        if (bitcnt_q != BIT_W'(7)) begin
                            shift_q  <= {shift_q[6:0], 1'b0};
                            di_q     <= shift_q[6];
                            bitcnt_q <= bitcnt_q + BIT_W'(1);
                            state_q  <= LOW;
                        end else if (row_q && (bytecnt_q < ROW_COUNT)) begin
                            dreq_q  <= 1'b1;
                            state_q <= LOAD;
                        end else begin
                            state_q <= FINISH;
                        end
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end
                // SCK parks low here for as long as the data source stalls.
                LOAD: begin
                    if (bus.data_valid) begin
                        shift_q   <= bus.data_in;
                        di_q      <= bus.data_in[7];
                        bitcnt_q  <= '0;
                        bytecnt_q <= bytecnt_q + BYTE_W'(1);
                        dreq_q    <= 1'b0;
                        state_q   <= LOW;
                    end
                end
                FINISH: begin
                    if (div_end_c) begin
                        div_q   <= '0;
                        ss_q    <= 1'b1;
                        state_q <= GAP;
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end
                GAP: begin
                    if (div_end_c) begin
                        div_q   <= '0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        rdy_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_osd_spi_master.sv
// Bench for osd_spi_master: two instances (CLK_DIV=2/ROW_BYTES=256 and
// CLK_DIV=1/ROW_BYTES=4) checked against a cycle-sampled SPI slave model.
module tb_osd_spi_master;
    localparam int unsigned DIV_A  = 2;
    localparam int unsigned ROWS_A = 256;
    localparam int unsigned DIV_B  = 1;
    localparam int unsigned ROWS_B = 4;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic reset_a, reset_b;
    logic busy_a, done_a, sck_a, ss_a, di_a;
    logic busy_b, done_b, sck_b, ss_b, di_b;

    osd_spi_master_if ifa ();
    osd_spi_master_if ifb ();

    osd_spi_master #(.CLK_DIV(DIV_A), .ROW_BYTES(ROWS_A)) dut_a (
        .clk_sys(clk_sys), .reset(reset_a), .bus(ifa), .busy(busy_a), .done(done_a),
        .SPI_SCK(sck_a), .SPI_SS3(ss_a), .SPI_DI(di_a)
    );

    osd_spi_master #(.CLK_DIV(DIV_B), .ROW_BYTES(ROWS_B)) dut_b (
        .clk_sys(clk_sys), .reset(reset_b), .bus(ifb), .busy(busy_b), .done(done_b),
        .SPI_SCK(sck_b), .SPI_SS3(ss_b), .SPI_DI(di_b)
    );

    logic [7:0] tx_data [256];
    int         waits   [256];
    int         n_tests = 0;
    int         n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic sample(input bit b, output logic sck, output logic ss, output logic di,
                          output logic dr, output logic dn, output logic bsy, output logic rdy);
        if (b) begin
            sck = sck_b; ss = ss_b; di = di_b; dr = ifb.data_ready;
            dn = done_b; bsy = busy_b; rdy = ifb.cmd_ready;
        end else begin
            sck = sck_a; ss = ss_a; di = di_a; dr = ifa.data_ready;
            dn = done_a; bsy = busy_a; rdy = ifa.cmd_ready;
        end
    endtask

    task automatic drive_cmd(input bit b, input logic v, input logic wr, input logic en,
                             input logic [2:0] row);
        if (b) begin
            ifb.cmd_valid = v; ifb.cmd_write = wr; ifb.cmd_enable = en; ifb.cmd_row = row;
        end else begin
            ifa.cmd_valid = v; ifa.cmd_write = wr; ifa.cmd_enable = en; ifa.cmd_row = row;
        end
    endtask

    task automatic drive_data(input bit b, input logic dv, input logic [7:0] din);
        if (b) begin ifb.data_valid = dv; ifb.data_in = din; end
        else   begin ifa.data_valid = dv; ifa.data_in = din; end
    endtask

    task automatic set_reset(input bit b, input logic r);
        if (b) reset_b = r;
        else   reset_a = r;
    endtask

    // One command frame. Expected bytes, SS3-low length and done position are
    // derived from the byte count, CLK_DIV and the bench's own LOAD wait plan.
    task automatic run_frame(input bit b, input int div, input bit wr, input bit en,
                             input logic [2:0] row, input int nbytes, input bit hold,
                             input int abort_rise, input string tag, output int acc_wait);
        logic [7:0] exp_q[$];
        logic [7:0] rx_q[$];
        logic [7:0] sh, din;
        logic       sck, ss, di, dr, dn, bsy, rdy, p_sck, p_di, dv;
        int         ndata, nb, exp_ss, budget, hs, ld_wait, ss_low, rises, nbits;
        int         bad_hi, bad_lo, bad_di, bad_ld, bad_rb, n_done, done_cyc, last_low, run, idle_bad;
        bit         fin, aborted;

        ndata = wr ? nbytes : 0;
        nb    = 1 + ndata;
        exp_q.push_back(wr ? (8'h20 | {5'd0, row}) : (8'h40 | {7'd0, en}));
        exp_ss = nb * 16 * div + div;
        for (int k = 0; k < ndata; k++) begin
            exp_q.push_back(tx_data[k]);
            exp_ss += waits[k] + 1;
        end
        budget = exp_ss + 4 * div + 20;
        hs = 0; ld_wait = 0; ss_low = 0; rises = 0; nbits = 0; sh = 8'd0;
        bad_hi = 0; bad_lo = 0; bad_di = 0; bad_ld = 0; bad_rb = 0;
        n_done = 0; done_cyc = -1; last_low = -1; run = 0; p_sck = 1'b0; p_di = 1'b0;
        fin = 1'b0; aborted = 1'b0; idle_bad = 0;

        acc_wait = 0;
        drive_cmd(b, 1'b1, wr, en, row);
        sample(b, sck, ss, di, dr, dn, bsy, rdy);
        while (!rdy && acc_wait < 100) begin
            @(negedge clk_sys);
            acc_wait++;
            sample(b, sck, ss, di, dr, dn, bsy, rdy);
        end
        check({tag, " accept_ready"}, 32'(rdy), 32'd1);
        p_di = 1'b0;

        for (int cyc = 0; cyc < budget && !fin; cyc++) begin
            @(negedge clk_sys);
            if (cyc == 0 && !hold)
                drive_cmd(b, 1'b0, 1'($urandom), 1'($urandom), 3'($urandom));
            sample(b, sck, ss, di, dr, dn, bsy, rdy);
            if (cyc == 0) p_di = di;
            if (bsy && rdy) bad_rb++;
            if (dr && (sck || ss)) bad_ld++;
            if (sck && !p_sck) rises++;
            if (!ss) begin
                ss_low++;
                last_low = cyc;
                if (sck == p_sck) run++;
                else begin
                    if (p_sck && run != div) bad_hi++;
                    if (!p_sck && run < div) bad_lo++;
                    run = 1;
                    if (sck) begin
                        if (di !== p_di) bad_di++;
                        sh = {sh[6:0], di};
                        nbits++;
                        if (nbits == 8) begin rx_q.push_back(sh); nbits = 0; end
                    end
                end
            end
            if (abort_rise > 0 && rises == abort_rise) begin
                // Reset lands mid-byte together with a competing command request.
                set_reset(b, 1'b1);
                drive_cmd(b, 1'b1, 1'b0, 1'b1, 3'd0);
                drive_data(b, 1'b0, 8'd0);
                @(negedge clk_sys);
                sample(b, sck, ss, di, dr, dn, bsy, rdy);
                check({tag, " rst_ss"}, 32'(ss), 32'd1);
                check({tag, " rst_sck"}, 32'(sck), 32'd0);
                check({tag, " rst_di"}, 32'(di), 32'd0);
                check({tag, " rst_busy"}, 32'(bsy), 32'd0);
                check({tag, " rst_ready"}, 32'(rdy), 32'd1);
                check({tag, " rst_dready"}, 32'(dr), 32'd0);
                @(negedge clk_sys);
                set_reset(b, 1'b0);
                drive_cmd(b, 1'b0, 1'b0, 1'b0, 3'd0);
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk_sys);
                    sample(b, sck, ss, di, dr, dn, bsy, rdy);
                    if (!ss || sck || bsy || dn || !rdy) idle_bad++;
                end
                check({tag, " post_reset_idle"}, 32'(idle_bad), 32'd0);
                aborted = 1'b1;
                fin = 1'b1;
            end else begin
                if (dr && hs < ndata) begin
                    if (ld_wait < waits[hs]) begin
                        dv = 1'b0; din = 8'($urandom); ld_wait++;
                    end else begin
                        dv = 1'b1; din = tx_data[hs]; hs++; ld_wait = 0;
                    end
                end else begin
                    dv = 1'($urandom); din = 8'($urandom);
                end
                drive_data(b, dv, din);
                if (dn) begin
                    n_done++;
                    done_cyc = cyc;
                    check({tag, " busy_at_done"}, 32'(bsy), 32'd0);
                    check({tag, " ready_at_done"}, 32'(rdy), 32'd1);
                    fin = 1'b1;
                end
                p_sck = sck;
                p_di  = di;
            end
        end

        if (!aborted) begin
            check({tag, " finished"}, 32'(fin), 32'd1);
            check({tag, " done_count"}, 32'(n_done), 32'd1);
            check({tag, " ss_low_cycles"}, 32'(ss_low), 32'(exp_ss));
            check({tag, " done_after_ss"}, 32'(done_cyc - last_low), 32'(div + 1));
            check({tag, " sck_rises"}, 32'(rises), 32'(nb * 8));
            check({tag, " handshakes"}, 32'(hs), 32'(ndata));
            check({tag, " sck_high_width"}, 32'(bad_hi), 32'd0);
            check({tag, " sck_low_width"}, 32'(bad_lo), 32'd0);
            check({tag, " di_stable"}, 32'(bad_di), 32'd0);
            check({tag, " load_parked"}, 32'(bad_ld), 32'd0);
            check({tag, " ready_while_busy"}, 32'(bad_rb), 32'd0);
            check({tag, " rx_count"}, 32'(rx_q.size()), 32'(nb));
            for (int i = 0; i < nb && i < rx_q.size(); i++)
                check($sformatf("%s byte%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
        end
        drive_data(b, 1'b0, 8'd0);
    endtask

    task automatic plan(input int n, input int max_wait, input bit by_index);
        for (int k = 0; k < 256; k++) begin
            tx_data[k] = by_index ? 8'(k) : 8'($urandom);
            waits[k]   = (k < n && max_wait > 0) ? int'($urandom_range(max_wait, 0)) : 0;
        end
    endtask

    initial begin
        logic sck, ss, di, dr, dn, bsy, rdy;
        int   acc;
        reset_a = 1'b1;
        reset_b = 1'b1;
        drive_cmd(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        drive_cmd(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        drive_data(1'b0, 1'b0, 8'd0);
        drive_data(1'b1, 1'b0, 8'd0);
        repeat (3) @(negedge clk_sys);
        for (int b = 0; b < 2; b++) begin
            sample(b[0], sck, ss, di, dr, dn, bsy, rdy);
            check($sformatf("reset%0d ss", b), 32'(ss), 32'd1);
            check($sformatf("reset%0d sck", b), 32'(sck), 32'd0);
            check($sformatf("reset%0d di", b), 32'(di), 32'd0);
            check($sformatf("reset%0d dready", b), 32'(dr), 32'd0);
            check($sformatf("reset%0d busy", b), 32'(bsy), 32'd0);
            check($sformatf("reset%0d done", b), 32'(dn), 32'd0);
        end
        reset_a = 1'b0;
        reset_b = 1'b0;
        @(negedge clk_sys);
        check("ready_after_reset", 32'(ifa.cmd_ready), 32'd1);

        plan(0, 0, 1'b0);
        run_frame(1'b0, DIV_A, 1'b0, 1'b1, 3'd0, 0, 1'b0, -1, "enable1", acc);
        run_frame(1'b0, DIV_A, 1'b0, 1'b0, 3'd0, 0, 1'b0, -1, "enable0", acc);

        plan(0, 0, 1'b1);
        run_frame(1'b0, DIV_A, 1'b1, 1'b0, 3'd5, ROWS_A, 1'b0, -1, "row5", acc);

        plan(0, 0, 1'b0);
        waits[2] = 50;
        run_frame(1'b0, DIV_A, 1'b1, 1'b0, 3'($urandom), ROWS_A, 1'b0, -1, "stall", acc);

        plan(ROWS_A, 3, 1'b0);
        run_frame(1'b0, DIV_A, 1'b1, 1'b0, 3'($urandom), ROWS_A, 1'b0, -1, "rand_row", acc);
        run_frame(1'b0, DIV_A, 1'b0, 1'($urandom), 3'd0, 0, 1'b0, -1, "rand_en", acc);

        plan(0, 0, 1'b0);
        tx_data[0] = 8'hA5; tx_data[1] = 8'h5A; tx_data[2] = 8'hFF; tx_data[3] = 8'h00;
        run_frame(1'b1, DIV_B, 1'b1, 1'b0, 3'd0, ROWS_B, 1'b0, -1, "div1_row0", acc);
        for (int r = 0; r < 3; r++) begin
            plan(ROWS_B, 4, 1'b0);
            run_frame(1'b1, DIV_B, 1'b1, 1'b0, 3'($urandom), ROWS_B, 1'b0, -1,
                      $sformatf("div1_rand%0d", r), acc);
        end

        plan(0, 0, 1'b0);
        run_frame(1'b0, DIV_A, 1'b1, 1'b0, 3'd2, ROWS_A, 1'b0, 92, "abort", acc);
        run_frame(1'b0, DIV_A, 1'b0, 1'b1, 3'd0, 0, 1'b0, -1, "after_abort", acc);

        run_frame(1'b0, DIV_A, 1'b0, 1'b1, 3'd0, 0, 1'b1, -1, "hold1", acc);
        run_frame(1'b0, DIV_A, 1'b0, 1'b0, 3'd0, 0, 1'b0, -1, "hold2", acc);
        check("hold2 accept_wait", 32'(acc), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
